multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and produces the datapath strobes and selects.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct.
- Talks to a shared instruction/data memory through a req/ready handshake, with an optional wait timeout.

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_mem_timer.sv | 36 +++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp
// codes, FSM state encodings and datapath select codes.
package mc_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FSM state encodings (also exported on state_o)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;

  // ALU B-operand select
  localparam logic [1:0] ALUB_REGB   = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open and are covered by the timeout
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait timer: counts stalled request cycles and flags when the
// count reaches MEM_TIMEOUT while still stalled. MEM_TIMEOUT = 0 disables it.
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Limit compare; only meaningful while the request is still stalled
  always_comb begin
    expired = (MEM_TIMEOUT != 0) && waiting && (cnt_q == LIMIT);
  end

  // Count stalled cycles; restart on a state change or after an abort
  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) cnt_d = '0;
    else if (waiting)     cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs decode from the
// state register (plus opcode / mem_ready where needed). Strobes are gated
// off while in reset and on a memory timeout abort.
// Optional macro MC_BNE_EN adds the BNEEX state for opcode 000101.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_error,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic       waiting, expired, strobe_en;
  logic       mem_req_r, mem_we_r, ir_write_r, pc_write_r, branch_r, branch_ne_r;
  logic       reg_write_r, illegal_r;

  // A memory state with no completion this cycle is a stall cycle
  always_comb begin
    waiting = is_mem_state(state_q) && !mem_ready;
  end

  mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .clear   (state_d != state_q),
    .expired (expired)
  );

  // Per-state output decode and next-state selection
  always_comb begin
    state_d     = state_q;
    mem_req_r   = 1'b0;
    mem_we_r    = 1'b0;
    ir_write_r  = 1'b0;
    pc_write_r  = 1'b0;
    branch_r    = 1'b0;
    branch_ne_r = 1'b0;
    reg_write_r = 1'b0;
    illegal_r   = 1'b0;
    iord        = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_REGB;
    alu_op      = ALUOP_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_r  = 1'b1;
        alu_src_b  = ALUB_FOUR;
        ir_write_r = mem_ready;
        pc_write_r = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            illegal_r = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_r = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_r = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_r = 1'b1;
        mem_we_r  = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst     = 1'b1;
        reg_write_r = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch_r  = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_r = 1'b1;
        state_d     = S_FETCH;
      end
      S_JEX: begin
        pc_src     = PCSRC_JUMP;
        pc_write_r = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alu_src_a   = 1'b1;
        alu_op      = ALUOP_SUB;
        branch_r    = 1'b1;
        branch_ne_r = 1'b1;
        pc_src      = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // A timed-out access is abandoned and the instruction restarts at fetch
    if (expired) state_d = S_FETCH;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Strobe gating: reset kills everything, an abort leaves only mem_error
  always_comb begin
    strobe_en  = rst_n && !expired;
    mem_req    = strobe_en && mem_req_r;
    mem_we     = strobe_en && mem_we_r;
    ir_write   = strobe_en && ir_write_r;
    pc_write   = strobe_en && pc_write_r;
    branch     = strobe_en && branch_r;
    reg_write  = strobe_en && reg_write_r;
    illegal_op = strobe_en && illegal_r;
    mem_error  = rst_n && expired;
`ifdef MC_BNE_EN
    branch_ne  = branch_ne_r;
`else
    branch_ne  = 1'b0;
`endif
    state_o    = state_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed test of multicycle_control with MEM_TIMEOUT = 4. Inputs change
// 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, branch, branch_ne;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, mem_error;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.MEM_TIMEOUT(4), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .mem_error(mem_error),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
    #3;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if ({mem_req, ir_write, pc_write, mem_we, reg_write, mem_error, illegal_op} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000000", {mem_req, ir_write, pc_write, mem_we, reg_write, mem_error, illegal_op});
    end
    step;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step;
    total++; if (state_o !== 4'd0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL reset_release state=%0d mem_req=%b exp state=0 mem_req=1", state_o, mem_req);
    end
  endtask

  task automatic test_lw;
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       ew [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++; if (state_o !== es[i] || reg_write !== ew[i] || mem_to_reg !== ew[i]) begin
        bad++; $display("FAIL lw_c%0d state=%0d rw=%b m2r=%b exp state=%0d rw=%b", i, state_o, reg_write, mem_to_reg, es[i], ew[i]);
      end
      if (i == 0) begin
        total++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin bad++; $display("FAIL lw_fetch ir=%b pc=%b exp 1 1", ir_write, pc_write); end
      end
      if (i == 3) begin
        total++; if (mem_req !== 1'b1 || iord !== 1'b1 || mem_we !== 1'b0) begin
          bad++; $display("FAIL lw_memrd req=%b iord=%b we=%b exp 1 1 0", mem_req, iord, mem_we);
        end
      end
      if (i < 5) step;
    end
  endtask

  task automatic test_rtype;
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (state_o !== es[i]) begin bad++; $display("FAIL rtype_c%0d state=%0d exp=%0d", i, state_o, es[i]); end
      if (i == 2) begin
        total++; if (alu_op !== 2'b10 || alu_src_a !== 1'b1 || reg_write !== 1'b0) begin
          bad++; $display("FAIL rtype_ex aluop=%b srca=%b rw=%b exp 10 1 0", alu_op, alu_src_a, reg_write);
        end
      end
      if (i == 3) begin
        total++; if (reg_dst !== 1'b1 || reg_write !== 1'b1) begin bad++; $display("FAIL rtype_wb regdst=%b rw=%b exp 1 1", reg_dst, reg_write); end
      end
      if (i < 4) step;
    end
  endtask

  task automatic test_branch_jump_addi;
    opcode = 6'b000100; mem_ready = 1'b1;
    step; step;
    total++; if (state_o !== 4'd8 || branch !== 1'b1 || alu_op !== 2'b01 || pc_src !== 2'b01 || branch_ne !== 1'b0) begin
      bad++; $display("FAIL beq_ex state=%0d br=%b bne=%b aluop=%b pcsrc=%b exp 8 1 0 01 01", state_o, branch, branch_ne, alu_op, pc_src);
    end
    opcode = 6'b000010;
    step;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL beq_done state=%0d exp=0", state_o); end
    step; step;
    total++; if (state_o !== 4'd11 || pc_write !== 1'b1 || pc_src !== 2'b10) begin
      bad++; $display("FAIL j_ex state=%0d pcw=%b pcsrc=%b exp 11 1 10", state_o, pc_write, pc_src);
    end
    opcode = 6'b001000;
    step; step; step;
    total++; if (state_o !== 4'd9 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || reg_write !== 1'b0) begin
      bad++; $display("FAIL addi_ex state=%0d srca=%b srcb=%b rw=%b exp 9 1 10 0", state_o, alu_src_a, alu_src_b, reg_write);
    end
    step;
    total++; if (state_o !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
      bad++; $display("FAIL addi_wb state=%0d rw=%b regdst=%b m2r=%b exp 10 1 0 0", state_o, reg_write, reg_dst, mem_to_reg);
    end
    step;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL addi_done state=%0d exp=0", state_o); end
  endtask

  task automatic test_sw_wait;
    opcode = 6'b101011; mem_ready = 1'b1;
    step; step;
    total++; if (state_o !== 4'd2) begin bad++; $display("FAIL sw_memadr state=%0d exp=2", state_o); end
    mem_ready = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ready = 1'b1; #1; end
      total++; if (state_o !== 4'd5 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_error !== 1'b0) begin
        bad++; $display("FAIL sw_wait_c%0d state=%0d req=%b we=%b err=%b exp 5 1 1 0", i, state_o, mem_req, mem_we, mem_error);
      end
      step;
    end
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL sw_done state=%0d exp=0", state_o); end
  endtask

  task automatic test_illegal;
    opcode = 6'b111111; mem_ready = 1'b1;
    #1;
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_pre got=%b exp=0", illegal_op); end
    step;
    total++; if (state_o !== 4'd1 || illegal_op !== 1'b1 || reg_write !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL ill_decode state=%0d ill=%b rw=%b we=%b exp 1 1 0 0", state_o, illegal_op, reg_write, mem_we);
    end
    step;
    total++; if (state_o !== 4'd0 || illegal_op !== 1'b0) begin
      bad++; $display("FAIL ill_after state=%0d ill=%b exp 0 0", state_o, illegal_op);
    end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (state_o !== 4'd0 || ir_write !== 1'b0 || mem_error !== (i == 4) || mem_req !== (i != 4)) begin
        bad++; $display("FAIL to_c%0d state=%0d ir=%b err=%b req=%b exp err=%b req=%b", i, state_o, ir_write, mem_error, mem_req, i == 4, i != 4);
      end
      step;
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (state_o !== 4'd0 || mem_error !== 1'b0 || mem_req !== 1'b1) begin
        bad++; $display("FAIL to_restart_c%0d state=%0d err=%b req=%b exp 0 0 1", i, state_o, mem_error, mem_req);
      end
      step;
    end
    mem_ready = 1'b1; opcode = 6'b111111;
    #1;
    total++; if (mem_error !== 1'b0 || ir_write !== 1'b1) begin
      bad++; $display("FAIL to_ready_wins err=%b ir=%b exp 0 1", mem_error, ir_write);
    end
    step;
    total++; if (state_o !== 4'd1) begin bad++; $display("FAIL to_decode state=%0d exp=1", state_o); end
    step;
  endtask

  task automatic test_reset_mid;
    opcode = 6'b101011; mem_ready = 1'b1;
    step; step;
    mem_ready = 1'b0;
    step;
    total++; if (state_o !== 4'd5 || mem_we !== 1'b1) begin bad++; $display("FAIL rmid_pre state=%0d we=%b exp 5 1", state_o, mem_we); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || mem_req !== 1'b0 || state_o !== 4'd0) begin
      bad++; $display("FAIL rmid_drop we=%b req=%b state=%0d exp 0 0 0", mem_we, mem_req, state_o);
    end
    step;
    rst_n = 1'b1;
    step;
    total++; if (state_o !== 4'd0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL rmid_release state=%0d req=%b exp 0 1", state_o, mem_req);
    end
  endtask

  task automatic test_bne;
    opcode = 6'b000101; mem_ready = 1'b1;
    step;
`ifdef MC_BNE_EN
    total++; if (state_o !== 4'd1 || illegal_op !== 1'b0) begin bad++; $display("FAIL bne_decode state=%0d ill=%b exp 1 0", state_o, illegal_op); end
    step;
    total++; if (state_o !== 4'd12 || branch !== 1'b1 || branch_ne !== 1'b1 || alu_op !== 2'b01 || pc_src !== 2'b01) begin
      bad++; $display("FAIL bne_ex state=%0d br=%b bne=%b aluop=%b pcsrc=%b exp 12 1 1 01 01", state_o, branch, branch_ne, alu_op, pc_src);
    end
    step;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL bne_done state=%0d exp=0", state_o); end
`else
    total++; if (state_o !== 4'd1 || illegal_op !== 1'b1 || branch_ne !== 1'b0) begin
      bad++; $display("FAIL bne_illegal state=%0d ill=%b bne=%b exp 1 1 0", state_o, illegal_op, branch_ne);
    end
    step;
    total++; if (state_o !== 4'd0 || illegal_op !== 1'b0) begin bad++; $display("FAIL bne_after state=%0d ill=%b exp 0 0", state_o, illegal_op); end
`endif
  endtask

  initial begin
    test_reset;
    test_lw;
    test_rtype;
    test_branch_jump_addi;
    test_sw_wait;
    test_illegal;
    test_timeout;
    test_reset_mid;
    test_bne;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
